// File: rtl/pc_sequencer.sv
// Fetch-control sequencer: picks the next PC among sequential advance, EX
// redirects, trap entry/return and the boot vector, and drives the flushes.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int unsigned BOOT_CYCLES  = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] pc,
    input  logic        imem_ready,
    input  logic        hazard_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        trap_req,
    input  logic [31:0] trap_pc,
    input  logic [3:0]  trap_cause,
    input  logic        mret,
    output logic [31:0] next_pc,
    output logic        pc_en,
    output logic        flush_if,
    output logic        flush_id,
    output logic [31:0] epc,
    output logic [3:0]  cause,
    output logic        in_handler,
    output logic        halted
);

    localparam int unsigned CNT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(BOOT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_BOOT,
        S_RUN,
        S_REDIR_WAIT,
        S_TRAP,
        S_HALT
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] boot_cnt, boot_cnt_nxt;
    logic [31:0]      pend_target, pend_target_nxt;
    logic [31:0]      epc_nxt;
    logic [3:0]       cause_nxt;
    logic             in_handler_nxt;
    logic             halted_nxt;
    logic             trap_hit;

    // State and architectural trap registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_BOOT;
            boot_cnt    <= CNT_INIT;
            pend_target <= '0;
            epc         <= '0;
            cause       <= '0;
            in_handler  <= 1'b0;
            halted      <= 1'b0;
        end else begin
            state       <= state_nxt;
            boot_cnt    <= boot_cnt_nxt;
            pend_target <= pend_target_nxt;
            epc         <= epc_nxt;
            cause       <= cause_nxt;
            in_handler  <= in_handler_nxt;
            halted      <= halted_nxt;
        end
    end

    // Next-state and fetch-control outputs
    always_comb begin
        state_nxt       = state;
        boot_cnt_nxt    = boot_cnt;
        pend_target_nxt = pend_target;
        epc_nxt         = epc;
        cause_nxt       = cause;
        in_handler_nxt  = in_handler;
        halted_nxt      = halted;
        next_pc         = pc;
        pc_en           = 1'b0;
        flush_if        = 1'b0;
        flush_id        = 1'b0;

        // Traps are honoured in RUN and REDIR_WAIT ahead of everything else
        trap_hit = trap_req && ((state == S_RUN) || (state == S_REDIR_WAIT));

        if (trap_hit) begin
            flush_if = 1'b1;
            flush_id = 1'b1;
            if (in_handler) begin
                halted_nxt = 1'b1;
                state_nxt  = S_HALT;
            end else begin
                epc_nxt   = trap_pc;
                cause_nxt = trap_cause;
                state_nxt = S_TRAP;
            end
        end else begin
            case (state)
                S_BOOT: begin
                    next_pc = RESET_VECTOR;
                    if (boot_cnt == '0) begin
                        pc_en     = 1'b1;
                        state_nxt = S_RUN;
                    end else begin
                        flush_if     = 1'b1;
                        flush_id     = 1'b1;
                        boot_cnt_nxt = boot_cnt - CNT_W'(1);
                    end
                end
                S_RUN: begin
                    if (mret || redirect_valid) begin
                        next_pc  = mret ? epc : redirect_target;
                        flush_if = 1'b1;
                        flush_id = 1'b1;
                        pc_en    = imem_ready;
                        if (mret) begin
                            in_handler_nxt = 1'b0;
                        end
                        if (!imem_ready) begin
                            pend_target_nxt = next_pc;
                            state_nxt       = S_REDIR_WAIT;
                        end
                    end else if (!hazard_stall && imem_ready) begin
                        next_pc = pc + 32'd4;
                        pc_en   = 1'b1;
                    end
                end
                S_REDIR_WAIT: begin
                    next_pc  = pend_target;
                    flush_if = 1'b1;
                    pc_en    = imem_ready;
                    if (imem_ready) begin
                        state_nxt = S_RUN;
                    end
                end
                S_TRAP: begin
                    next_pc        = TRAP_VECTOR;
                    pc_en          = 1'b1;
                    flush_if       = 1'b1;
                    in_handler_nxt = 1'b1;
                    state_nxt      = S_RUN;
                end
                S_HALT: begin
                    flush_if = 1'b1;
                    flush_id = 1'b1;
                end
                default: begin
                    state_nxt = S_BOOT;
                end
            endcase
        end

        // Held in reset: fetch parked on the boot vector with pipeline flushed
        if (!reset_n) begin
            next_pc  = RESET_VECTOR;
            pc_en    = 1'b0;
            flush_if = 1'b1;
            flush_id = 1'b1;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, hand sequences for reset
// and wrap, then random stimulus against a flag-based reference model.
module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0100;
    localparam int          BC = 4;

    logic        clock;
    logic        reset_n;
    logic [31:0] pc;
    logic        imem_ready, hazard_stall, redirect_valid, trap_req, mret;
    logic [31:0] redirect_target, trap_pc;
    logic [3:0]  trap_cause;
    logic [31:0] next_pc, epc;
    logic        pc_en, flush_if, flush_id, in_handler, halted;
    logic [3:0]  cause;

    pc_sequencer #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV), .BOOT_CYCLES(BC)) dut (
        .clock(clock), .reset_n(reset_n), .pc(pc), .imem_ready(imem_ready),
        .hazard_stall(hazard_stall), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .trap_req(trap_req), .trap_pc(trap_pc),
        .trap_cause(trap_cause), .mret(mret), .next_pc(next_pc), .pc_en(pc_en),
        .flush_if(flush_if), .flush_id(flush_id), .epc(epc), .cause(cause),
        .in_handler(in_handler), .halted(halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // The PC register this block drives
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) pc <= 32'h0;
        else if (pc_en) pc <= next_pc;
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: boot countdown plus mode flags
    bit          m_booting, m_waiting, m_trapping, m_frozen, m_inh;
    int          m_cnt;
    logic [31:0] m_pend, m_epc;
    logic [3:0]  m_cause;
    bit          n_booting, n_waiting, n_trapping, n_frozen, n_inh;
    int          n_cnt;
    logic [31:0] n_pend, n_epc;
    logic [3:0]  n_cause;
    logic [31:0] e_npc;
    logic        e_en, e_fi, e_fd;

    task automatic model_reset();
        m_booting = 1; m_cnt = BC - 1;
        m_waiting = 0; m_trapping = 0; m_frozen = 0; m_inh = 0;
        m_pend = 0; m_epc = 0; m_cause = 0;
    endtask

    task automatic model_eval();
        n_booting = m_booting; n_waiting = m_waiting; n_trapping = m_trapping;
        n_frozen = m_frozen; n_inh = m_inh; n_cnt = m_cnt;
        n_pend = m_pend; n_epc = m_epc; n_cause = m_cause;
        e_npc = pc; e_en = 0; e_fi = 0; e_fd = 0;
        if (m_frozen) begin
            e_fi = 1; e_fd = 1;
        end else if (m_booting) begin
            e_npc = RV;
            if (m_cnt == 0) begin
                e_en = 1; n_booting = 0;
            end else begin
                e_fi = 1; e_fd = 1; n_cnt = m_cnt - 1;
            end
        end else if (m_trapping) begin
            e_npc = TV; e_en = 1; e_fi = 1; n_inh = 1; n_trapping = 0;
        end else if (trap_req) begin
            e_fi = 1; e_fd = 1; n_waiting = 0;
            if (m_inh) n_frozen = 1;
            else begin
                n_epc = trap_pc; n_cause = trap_cause; n_trapping = 1;
            end
        end else if (m_waiting) begin
            e_npc = m_pend; e_fi = 1; e_en = imem_ready;
            if (imem_ready) n_waiting = 0;
        end else if (mret || redirect_valid) begin
            e_npc = mret ? m_epc : redirect_target;
            e_fi = 1; e_fd = 1; e_en = imem_ready;
            if (mret) n_inh = 0;
            if (!imem_ready) begin
                n_waiting = 1; n_pend = e_npc;
            end
        end else if (!hazard_stall && imem_ready) begin
            e_npc = pc + 32'd4; e_en = 1;
        end
    endtask

    task automatic model_commit();
        m_booting = n_booting; m_waiting = n_waiting; m_trapping = n_trapping;
        m_frozen = n_frozen; m_inh = n_inh; m_cnt = n_cnt;
        m_pend = n_pend; m_epc = n_epc; m_cause = n_cause;
    endtask

    logic [31:0] s_npc, s_pc;
    logic        s_en, s_fi, s_fd;

    // One clock: check combinational outputs mid-cycle, registered ones after the edge
    task automatic cycle();
        @(negedge clock);
        model_eval();
        s_npc = next_pc; s_en = pc_en; s_fi = flush_if; s_fd = flush_id;
        chk("next_pc", next_pc, e_npc);
        chk("pc_en", 32'(pc_en), 32'(e_en));
        chk("flush_if", 32'(flush_if), 32'(e_fi));
        chk("flush_id", 32'(flush_id), 32'(e_fd));
        @(posedge clock);
        model_commit();
        #1;
        s_pc = pc;
        chk("epc", epc, m_epc);
        chk("cause", 32'(cause), 32'(m_cause));
        chk("in_handler", 32'(in_handler), 32'(m_inh));
        chk("halted", 32'(halted), 32'(m_frozen));
    endtask

    task automatic idle_inputs();
        imem_ready = 1; hazard_stall = 0; redirect_valid = 0; redirect_target = 0;
        trap_req = 0; trap_pc = 0; trap_cause = 0; mret = 0;
    endtask

    // Asynchronous reset pulse; release lands between clock edges
    task automatic async_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("rst next_pc", next_pc, RV);
        chk("rst pc_en", 32'(pc_en), 32'd0);
        chk("rst flush_if", 32'(flush_if), 32'd1);
        chk("rst flush_id", 32'(flush_id), 32'd1);
        chk("rst epc", epc, 32'h0);
        chk("rst cause", 32'(cause), 32'd0);
        chk("rst in_handler", 32'(in_handler), 32'd0);
        chk("rst halted", 32'(halted), 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    typedef struct packed {
        logic rdy, stall, rv; logic [31:0] rt;
        logic tq; logic [31:0] tpc; logic [3:0] tc; logic mr;
        logic en; logic [31:0] npc; logic fi, fd; logic [31:0] pc_a;
        logic inh, hlt; logic [31:0] ep; logic [3:0] ca;
    } vec_t;

    function automatic vec_t mk(input int rdy, stall, rv, rt, tq, tpc, tc, mr,
                                input int en, npc, fi, fd, pc_a, inh, hlt, ep, ca);
        vec_t v;
        v.rdy = 1'(rdy); v.stall = 1'(stall); v.rv = 1'(rv); v.rt = 32'(rt);
        v.tq = 1'(tq); v.tpc = 32'(tpc); v.tc = 4'(tc); v.mr = 1'(mr);
        v.en = 1'(en); v.npc = 32'(npc); v.fi = 1'(fi); v.fd = 1'(fd);
        v.pc_a = 32'(pc_a); v.inh = 1'(inh); v.hlt = 1'(hlt); v.ep = 32'(ep); v.ca = 4'(ca);
        return v;
    endfunction

    vec_t tbl[23];
    int   frozen_cycles;

    initial begin
        // rdy stall rv rt | tq tpc tc mr | en npc fi fd pc_after inh hlt epc cause
        tbl[0]  = mk(1,0,0,0,     0,0,0,0,     0,0,1,1,0,         0,0,0,0);
        tbl[1]  = mk(1,0,0,0,     0,0,0,0,     0,0,1,1,0,         0,0,0,0);
        tbl[2]  = mk(1,0,0,0,     0,0,0,0,     0,0,1,1,0,         0,0,0,0);
        tbl[3]  = mk(1,0,0,0,     0,0,0,0,     1,0,0,0,0,         0,0,0,0);
        tbl[4]  = mk(1,0,0,0,     0,0,0,0,     1,4,0,0,4,         0,0,0,0);
        tbl[5]  = mk(1,0,0,0,     0,0,0,0,     1,8,0,0,8,         0,0,0,0);
        tbl[6]  = mk(1,0,1,'h20,  0,0,0,0,     1,'h20,1,1,'h20,   0,0,0,0);
        tbl[7]  = mk(1,1,0,0,     0,0,0,0,     0,'h20,0,0,'h20,   0,0,0,0);
        tbl[8]  = mk(1,1,0,0,     0,0,0,0,     0,'h20,0,0,'h20,   0,0,0,0);
        tbl[9]  = mk(1,1,1,'h80,  0,0,0,0,     1,'h80,1,1,'h80,   0,0,0,0);
        tbl[10] = mk(0,0,1,'h200, 0,0,0,0,     0,'h200,1,1,'h80,  0,0,0,0);
        tbl[11] = mk(0,0,0,0,     0,0,0,0,     0,'h200,1,0,'h80,  0,0,0,0);
        tbl[12] = mk(0,0,0,0,     0,0,0,0,     0,'h200,1,0,'h80,  0,0,0,0);
        tbl[13] = mk(1,0,0,0,     0,0,0,0,     1,'h200,1,0,'h200, 0,0,0,0);
        tbl[14] = mk(1,0,0,0,     1,'h44,5,0,  0,'h200,1,1,'h200, 0,0,'h44,5);
        tbl[15] = mk(0,0,0,0,     0,0,0,0,     1,'h100,1,0,'h100, 1,0,'h44,5);
        tbl[16] = mk(1,0,0,0,     0,0,0,0,     1,'h104,0,0,'h104, 1,0,'h44,5);
        tbl[17] = mk(1,0,0,0,     0,0,0,1,     1,'h44,1,1,'h44,   0,0,'h44,5);
        tbl[18] = mk(1,0,0,0,     1,'h48,2,0,  0,'h44,1,1,'h44,   0,0,'h48,2);
        tbl[19] = mk(1,0,0,0,     0,0,0,0,     1,'h100,1,0,'h100, 1,0,'h48,2);
        tbl[20] = mk(1,0,0,0,     1,'h100,7,0, 0,'h100,1,1,'h100, 1,1,'h48,2);
        tbl[21] = mk(1,0,1,'h300, 0,0,0,1,     0,'h100,1,1,'h100, 1,1,'h48,2);
        tbl[22] = mk(1,0,0,0,     0,0,0,0,     0,'h100,1,1,'h100, 1,1,'h48,2);

        reset_n = 1'b1;
        idle_inputs();
        #1;
        async_reset();

        foreach (tbl[i]) begin
            imem_ready = tbl[i].rdy; hazard_stall = tbl[i].stall;
            redirect_valid = tbl[i].rv; redirect_target = tbl[i].rt;
            trap_req = tbl[i].tq; trap_pc = tbl[i].tpc; trap_cause = tbl[i].tc;
            mret = tbl[i].mr;
            cycle();
            chk($sformatf("row%0d pc_en", i), 32'(s_en), 32'(tbl[i].en));
            chk($sformatf("row%0d next_pc", i), s_npc, tbl[i].npc);
            chk($sformatf("row%0d flush_if", i), 32'(s_fi), 32'(tbl[i].fi));
            chk($sformatf("row%0d flush_id", i), 32'(s_fd), 32'(tbl[i].fd));
            chk($sformatf("row%0d pc", i), s_pc, tbl[i].pc_a);
            chk($sformatf("row%0d in_handler", i), 32'(in_handler), 32'(tbl[i].inh));
            chk($sformatf("row%0d halted", i), 32'(halted), 32'(tbl[i].hlt));
            chk($sformatf("row%0d epc", i), epc, tbl[i].ep);
            chk($sformatf("row%0d cause", i), 32'(cause), 32'(tbl[i].ca));
        end

        // Sequential advance wraps past the top of the address space
        idle_inputs();
        async_reset();
        for (int i = 0; i < BC; i++) cycle();
        redirect_valid = 1; redirect_target = 32'hFFFF_FFFC;
        cycle();
        chk("wrap setup pc", s_pc, 32'hFFFF_FFFC);
        idle_inputs();
        cycle();
        chk("wrap next_pc", s_npc, 32'h0);
        chk("wrap pc", s_pc, 32'h0);

        // Reset while waiting on a back-pressured redirect restarts boot
        redirect_valid = 1; redirect_target = 32'h200; imem_ready = 0;
        cycle();
        redirect_valid = 0;
        cycle();
        chk("wait flush_if", 32'(s_fi), 32'd1);
        chk("wait pc_en", 32'(s_en), 32'd0);
        async_reset();
        idle_inputs();
        for (int i = 0; i < BC; i++) begin
            cycle();
            chk($sformatf("reboot%0d pc_en", i), 32'(s_en), (i == BC - 1) ? 32'd1 : 32'd0);
        end
        chk("reboot pc", s_pc, RV);

        // Random traffic against the model
        async_reset();
        frozen_cycles = 0;
        for (int n = 0; n < 3000; n++) begin
            if (frozen_cycles > 2 || $urandom_range(0, 399) == 0) begin
                frozen_cycles = 0;
                async_reset();
            end
            imem_ready     = ($urandom_range(0, 3) != 0);
            hazard_stall   = ($urandom_range(0, 3) == 0);
            redirect_valid = ($urandom_range(0, 5) == 0);
            redirect_target = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC
                                                          : ($urandom() & 32'hFFFF_FFFC);
            trap_req       = ($urandom_range(0, 24) == 0);
            trap_pc        = $urandom() & 32'hFFFF_FFFC;
            trap_cause     = 4'($urandom());
            mret           = ($urandom_range(0, 14) == 0);
            cycle();
            if (m_frozen) frozen_cycles++;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
